regfile_mp: RTL and testbench

Parametrised multi-read-port register file for the pipelined MIPS datapath; successor to the single-cycle two-read/one-write file. Adds N read ports, optional write-to-read bypass, a per-register pending-write scoreboard for hazard detection, and a post-reset clearing sequencer that zeroes every entry one per cycle. Sits between decode (reads, marks) and writeback (writes).

---
 rtl/rf_pkg.sv | 15 +
 rtl/rf_scoreboard.sv | 60 ++++++
 rtl/regfile_mp.sv | 99 +++++++++
 tb/tb_regfile_mp.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file.
// Holds the sequencer state encoding, the default data/address widths and
// the index of the hard-wired zero register.
package rf_pkg;

    localparam int RF_DW       = 32;
    localparam int RF_AW       = 5;
    localparam int RF_ZERO_REG = 0;

    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for the register file.
// One pending bit per register: set when a producer is issued (mark),
// cleared when that register is written back (we). Provides a busy flag
// per read port.
//
// Ports:
//   clk   - clock
//   rst   - synchronous active-low reset, clears every pending bit
//   run   - file is operational; mark/we are ignored otherwise
//   we/wa - writeback enable and address
//   mark  - set pending bit of register ma
//   ra    - packed read addresses, port i at [i*AW +: AW]
//   busy  - per-port pending flag
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int AW     = RF_AW,
    parameter int NRP    = 2,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic              mark,
    input  logic [AW-1:0]     ma,
    input  logic [NRP*AW-1:0] ra,
    output logic [NRP-1:0]    busy
);

    localparam int          DEPTH = 1 << AW;
    localparam logic [AW-1:0] ZERO = AW'(RF_ZERO_REG);

    logic [DEPTH-1:0] pend;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend <= '0;
        end else if (run) begin
            // NOTE: both updates are non-blocking to the same vector; the
            // later assignment wins, so a mark on the written register keeps
            // its pending bit set.
            if (we)
                pend[wa] <= 1'b0;
            if (mark && ma != ZERO)
                pend[ma] <= 1'b1;
        end
    end

    for (genvar i = 0; i < NRP; i++) begin : g_busy
        logic [AW-1:0] a;
        logic          hit;
        assign a   = ra[i*AW +: AW];
        // A same-cycle writeback to this register resolves the hazard early.
        assign hit = (BYPASS != 0) && we && (wa == a);
        assign busy[i] = run && (a != ZERO) && pend[a] && !hit;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file for the pipelined datapath.
// After reset a sequencer clears one entry per cycle; ready rises once every
// entry is zero. Register 0 always reads 0. Optional write-to-read bypass
// forwards same-cycle write data to matching read ports.
//
// Ports:
//   clk   - clock
//   rst   - synchronous active-low reset, restarts the clearing sequence
//   ready - clearing complete, file operational
//   ra/rd - packed read addresses/data, port i at [i*AW +: AW]/[i*DW +: DW]
//   rbusy - port i's register has an outstanding pending write
//   we/wa/wd - write port
//   mark/ma  - mark register ma as pending (producer issued)
module regfile_mp
    import rf_pkg::*;
#(
    parameter int DW     = RF_DW,
    parameter int AW     = RF_AW,
    parameter int NRP    = 2,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic [NRP*AW-1:0] ra,
    output logic [NRP*DW-1:0] rd,
    output logic [NRP-1:0]    rbusy,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DW-1:0]     wd,
    input  logic              mark,
    input  logic [AW-1:0]     ma
);

    localparam int            DEPTH = 1 << AW;
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ZERO  = AW'(RF_ZERO_REG);

    rf_state_t     state;
    logic [AW-1:0] cnt;
    logic [DW-1:0] mem [DEPTH];
    logic          run;

    assign run = (state == RF_RUN);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RF_INIT;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                RF_INIT: begin
                    cnt <= cnt + 1'b1;  // wraps to 0 on the last entry
                    if (cnt == LAST) begin
                        state <= RF_RUN;
                        ready <= 1'b1;
                    end
                end
                default: ready <= 1'b1;
            endcase
        end
    end

    // NOTE: the array has no reset branch so it can map onto RAM; the
    // clearing sequencer zeroes it one entry per cycle instead.
    always_ff @(posedge clk) begin
        if (rst && state == RF_INIT)
            mem[cnt] <= '0;
        else if (rst && run && we && wa != ZERO)
            mem[wa] <= wd;
    end

    for (genvar i = 0; i < NRP; i++) begin : g_read
        logic [AW-1:0] a;
        assign a = ra[i*AW +: AW];
        assign rd[i*DW +: DW] =
            (!run || a == ZERO)                  ? '0 :
            ((BYPASS != 0) && we && wa == a)     ? wd :
                                                   mem[a];
    end

    rf_scoreboard #(
        .AW     (AW),
        .NRP    (NRP),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .we   (we),
        .wa   (wa),
        .mark (mark),
        .ma   (ma),
        .ra   (ra),
        .busy (rbusy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp. Two instances share all inputs: one with
// write-to-read bypass, one without, so both read behaviours are checked
// against the same stimulus.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic [2*AW-1:0] ra;
    logic           we;
    logic [AW-1:0]  wa;
    logic [DW-1:0]  wd;
    logic           mark;
    logic [AW-1:0]  ma;

    logic           ready_b, ready_n;
    logic [2*DW-1:0] rd_b, rd_n;
    logic [1:0]     busy_b, busy_n;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DW(DW), .AW(AW), .NRP(2), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .ready(ready_b), .ra(ra), .rd(rd_b), .rbusy(busy_b),
        .we(we), .wa(wa), .wd(wd), .mark(mark), .ma(ma)
    );

    regfile_mp #(.DW(DW), .AW(AW), .NRP(2), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .ready(ready_n), .ra(ra), .rd(rd_n), .rbusy(busy_n),
        .we(we), .wa(wa), .wd(wd), .mark(mark), .ma(ma)
    );

    task automatic edge_to_negedge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; we = 1'b0; mark = 1'b0; wa = '0; wd = '0; ma = '0;
        ra = {5'd4, 5'd3};
        edge_to_negedge();
        edge_to_negedge();
        total++; if (ready_b !== 1'b0 || ready_n !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b/%b expected 0", ready_b, ready_n); end
        total++; if (rd_b !== '0 || rd_n !== '0) begin bad++; $display("FAIL reset_rd: got %h/%h expected 0", rd_b, rd_n); end
        total++; if (busy_b !== 2'b00 || busy_n !== 2'b00) begin bad++; $display("FAIL reset_busy: got %b/%b expected 00", busy_b, busy_n); end

        // Release reset with a write and a mark held: both must be dropped during INIT.
        we = 1'b1; wa = 5'd3; wd = 32'h0000DEAD; mark = 1'b1; ma = 5'd4;
        rst = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            edge_to_negedge();
            if (k < 32) begin
                total++; if (ready_b !== 1'b0 || ready_n !== 1'b0) begin bad++; $display("FAIL init_ready_k%0d: got %b/%b expected 0", k, ready_b, ready_n); end
                total++; if (rd_b !== '0 || busy_b !== 2'b00) begin bad++; $display("FAIL init_outputs_k%0d: got rd=%h busy=%b expected 0", k, rd_b, busy_b); end
            end
        end
        total++; if (ready_b !== 1'b1 || ready_n !== 1'b1) begin bad++; $display("FAIL ready_rise: got %b/%b expected 1", ready_b, ready_n); end
        total++; if (rd_b[31:0] !== 32'h0000DEAD) begin bad++; $display("FAIL first_write_bypass: got %h expected 0000dead", rd_b[31:0]); end
        total++; if (rd_n[31:0] !== 32'h0) begin bad++; $display("FAIL entry3_cleared: got %h expected 0", rd_n[31:0]); end
        mark = 1'b0;
        edge_to_negedge();
        we = 1'b0;
        #1;
        total++; if (rd_b[31:0] !== 32'h0000DEAD || rd_n[31:0] !== 32'h0000DEAD) begin bad++; $display("FAIL first_write_landed: got %h/%h expected 0000dead", rd_b[31:0], rd_n[31:0]); end
        total++; if (busy_b[1] !== 1'b0 || busy_n[1] !== 1'b0) begin bad++; $display("FAIL init_mark_dropped: got %b/%b expected 0", busy_b[1], busy_n[1]); end
    endtask

    task automatic test_bypass();
        we = 1'b1; wa = 5'd5; wd = 32'h12345678; ra = {5'd5, 5'd5};
        #1;
        total++; if (rd_b[31:0] !== 32'h12345678 || rd_b[63:32] !== 32'h12345678) begin bad++; $display("FAIL bypass_same_cycle: got %h expected 1234567812345678", rd_b); end
        total++; if (rd_n[31:0] !== 32'h0) begin bad++; $display("FAIL nobypass_old_value: got %h expected 0", rd_n[31:0]); end
        edge_to_negedge();
        we = 1'b0;
        #1;
        total++; if (rd_b[31:0] !== 32'h12345678 || rd_n[31:0] !== 32'h12345678) begin bad++; $display("FAIL write_next_cycle: got %h/%h expected 12345678", rd_b[31:0], rd_n[31:0]); end
        total++; if (rd_n[63:32] !== 32'h12345678) begin bad++; $display("FAIL same_addr_ports: got %h expected 12345678", rd_n[63:32]); end
    endtask

    task automatic test_zero_reg();
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra = {5'd0, 5'd0};
        #1;
        total++; if (rd_b !== '0 || rd_n !== '0) begin bad++; $display("FAIL zero_write_bypass: got %h/%h expected 0", rd_b, rd_n); end
        edge_to_negedge();
        we = 1'b0; mark = 1'b1; ma = 5'd0;
        #1;
        total++; if (rd_b !== '0 || rd_n !== '0) begin bad++; $display("FAIL zero_after_write: got %h/%h expected 0", rd_b, rd_n); end
        edge_to_negedge();
        mark = 1'b0;
        #1;
        total++; if (busy_b !== 2'b00 || busy_n !== 2'b00) begin bad++; $display("FAIL zero_mark_ignored: got %b/%b expected 00", busy_b, busy_n); end
    endtask

    task automatic test_scoreboard();
        mark = 1'b1; ma = 5'd7; ra = {5'd7, 5'd0};
        #1;
        total++; if (busy_b[1] !== 1'b0) begin bad++; $display("FAIL mark_not_yet: got %b expected 0", busy_b[1]); end
        edge_to_negedge();
        mark = 1'b0;
        #1;
        total++; if (busy_b[1] !== 1'b1 || busy_n[1] !== 1'b1) begin bad++; $display("FAIL mark_busy: got %b/%b expected 1", busy_b[1], busy_n[1]); end
        we = 1'b1; wa = 5'd7; wd = 32'h000000A5;
        #1;
        total++; if (busy_b[1] !== 1'b0 || rd_b[63:32] !== 32'h000000A5) begin bad++; $display("FAIL clear_bypass: got busy=%b rd=%h expected 0/000000a5", busy_b[1], rd_b[63:32]); end
        total++; if (busy_n[1] !== 1'b1 || rd_n[63:32] !== 32'h0) begin bad++; $display("FAIL clear_nobypass: got busy=%b rd=%h expected 1/0", busy_n[1], rd_n[63:32]); end
        edge_to_negedge();
        we = 1'b0;
        #1;
        total++; if (busy_b[1] !== 1'b0 || busy_n[1] !== 1'b0) begin bad++; $display("FAIL clear_done: got %b/%b expected 0", busy_b[1], busy_n[1]); end
        total++; if (rd_b[63:32] !== 32'h000000A5 || rd_n[63:32] !== 32'h000000A5) begin bad++; $display("FAIL clear_data: got %h/%h expected 000000a5", rd_b[63:32], rd_n[63:32]); end
    endtask

    task automatic test_mark_and_write();
        mark = 1'b1; ma = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'h1; ra = {5'd0, 5'd9};
        edge_to_negedge();
        mark = 1'b0; we = 1'b0;
        #1;
        total++; if (rd_b[31:0] !== 32'h1 || rd_n[31:0] !== 32'h1) begin bad++; $display("FAIL mark_write_data: got %h/%h expected 1", rd_b[31:0], rd_n[31:0]); end
        total++; if (busy_b[0] !== 1'b1 || busy_n[0] !== 1'b1) begin bad++; $display("FAIL mark_wins: got %b/%b expected 1", busy_b[0], busy_n[0]); end
    endtask

    task automatic test_reset_in_run();
        // Back-to-back writes fill r1..r31 with their own index.
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; wa = AW'(i); wd = DW'(i);
            edge_to_negedge();
        end
        we = 1'b0; ra = {5'd31, 5'd17};
        #1;
        total++; if (rd_b[31:0] !== 32'd17 || rd_n[63:32] !== 32'd31) begin bad++; $display("FAIL fill_readback: got %h/%h expected 11/1f", rd_b[31:0], rd_n[63:32]); end
        mark = 1'b1; ma = 5'd12;
        edge_to_negedge();
        mark = 1'b0; ra = {5'd12, 5'd12};
        #1;
        total++; if (busy_b !== 2'b11 || busy_n !== 2'b11) begin bad++; $display("FAIL fill_mark: got %b/%b expected 11", busy_b, busy_n); end

        rst = 1'b0;
        edge_to_negedge();
        rst = 1'b1;
        #1;
        total++; if (ready_b !== 1'b0 || ready_n !== 1'b0) begin bad++; $display("FAIL run_reset_ready: got %b/%b expected 0", ready_b, ready_n); end
        total++; if (busy_b !== 2'b00 || rd_b !== '0) begin bad++; $display("FAIL run_reset_outputs: got busy=%b rd=%h expected 0", busy_b, rd_b); end
        for (int k = 1; k <= 32; k++) begin
            edge_to_negedge();
            if (k == 31) begin
                total++; if (ready_b !== 1'b0) begin bad++; $display("FAIL reinit_ready_early: got %b expected 0", ready_b); end
            end
        end
        total++; if (ready_b !== 1'b1 || ready_n !== 1'b1) begin bad++; $display("FAIL reinit_ready: got %b/%b expected 1", ready_b, ready_n); end
        for (int i = 0; i < 32; i++) begin
            ra = {AW'(31 - i), AW'(i)};
            #1;
            total++; if (rd_b !== '0 || rd_n !== '0 || busy_b !== 2'b00 || busy_n !== 2'b00) begin
                bad++; $display("FAIL reinit_cleared_r%0d: got rd=%h/%h busy=%b/%b expected 0", i, rd_b, rd_n, busy_b, busy_n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_mark_and_write();
        test_reset_in_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
